// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS main control FSM. It sequences fetch, decode, execute, memory and writeback steps.
// Optional feature macro: MIPS_CTRL_ILLEGAL_OP_EN (unknown opcodes trap to EXC instead of acting as a NOP).
module mips_multicycle_ctrl #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_J     = 6'b000010,
    parameter logic [5:0] OP_ADDI  = 6'b001000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       instr_done,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_RWB    = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_ADDIEX = 4'd11,
        S_ADDIWB = 4'd12,
        S_EXC    = 4'd13
    } state_t;

    state_t state_q, state_d;
    logic   op_known;

    assign op_known = (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
                      (op == OP_BEQ)   || (op == OP_J)  || (op == OP_ADDI);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
`ifdef MIPS_CTRL_ILLEGAL_OP_EN
                state_d = S_EXC;
`else
                state_d = S_FETCH;
`endif
                if (op_known) begin
                    if (op == OP_LW || op == OP_SW) state_d = S_MEMADR;
                    else if (op == OP_RTYPE)        state_d = S_EXEC;
                    else if (op == OP_BEQ)          state_d = S_BRANCH;
                    else if (op == OP_J)            state_d = S_JUMP;
                    else                            state_d = S_ADDIEX;
                end
            end
            S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_d = S_RWB;
            S_RWB:    state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: state_d = S_FETCH;
`ifdef MIPS_CTRL_ILLEGAL_OP_EN
            S_EXC:    state_d = S_FETCH;
`else
            S_EXC:    state_d = S_IDLE;
`endif
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs decode straight from the state register so that reset clears them asynchronously.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        instr_done    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
`ifndef MIPS_CTRL_ILLEGAL_OP_EN
                instr_done = !op_known;
`endif
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                instr_done = mem_ready;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_RWB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                instr_done    = 1'b1;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                instr_done = 1'b1;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_ADDIWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
`ifdef MIPS_CTRL_ILLEGAL_OP_EN
            S_EXC: begin
                pc_write   = 1'b1;
                pc_source  = 2'b11;
                instr_done = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: walks every instruction class, memory stalls,
// a mid-instruction asynchronous reset and an unknown opcode, against hand-built control words.
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] op;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mips_multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .instr_done(instr_done), .state(state)
    );

    // Field order: pc_write pc_write_cond i_or_d mem_read mem_write ir_write
    //              mem_to_reg reg_dst reg_write alu_src_a alu_src_b alu_op pc_source instr_done
    logic [16:0] ctl;
    assign ctl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                  pc_source, instr_done};

    localparam logic [16:0] E_IDLE    = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] E_FETCH   = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
    localparam logic [16:0] E_FETCH_W = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
    localparam logic [16:0] E_DEC     = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
    localparam logic [16:0] E_DEC_NOP = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_1;
    localparam logic [16:0] E_MEMADR  = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
    localparam logic [16:0] E_MEMRD   = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] E_MEMWB   = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_1;
    localparam logic [16:0] E_MEMWR_W = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] E_MEMWR   = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_1;
    localparam logic [16:0] E_EXEC    = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
    localparam logic [16:0] E_RWB     = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_1;
    localparam logic [16:0] E_BRANCH  = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_1;
    localparam logic [16:0] E_JUMP    = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_1;
    localparam logic [16:0] E_ADDIEX  = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
    localparam logic [16:0] E_ADDIWB  = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_1;
    localparam logic [16:0] E_EXC     = 17'b1_0_0_0_0_0_0_0_0_0_00_00_11_1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1 with inputs already set; checks mid-cycle, returns at next posedge+1.
    task automatic cyc(input string tag, input logic [3:0] st, input logic [16:0] c);
        @(negedge clk);
        check({tag, "_state"}, {28'd0, state}, {28'd0, st});
        check({tag, "_ctl"}, {15'd0, ctl}, {15'd0, c});
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        op = 6'b100011;
        mem_ready = 1'b1;
        #2;
        check("reset_state", {28'd0, state}, 32'd0);
        check("reset_ctl", {15'd0, ctl}, {15'd0, E_IDLE});
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // LW, with one MEMRD wait and op changed while not sampled
        cyc("idle", 4'd0, E_IDLE);
        cyc("lw_fetch", 4'd1, E_FETCH);
        cyc("lw_decode", 4'd2, E_DEC);
        cyc("lw_memadr", 4'd3, E_MEMADR);
        op = 6'b000010; mem_ready = 1'b0;
        cyc("lw_memrd_wait", 4'd4, E_MEMRD);
        mem_ready = 1'b1;
        cyc("lw_memrd", 4'd4, E_MEMRD);
        cyc("lw_memwb", 4'd5, E_MEMWB);

        // SW with three write wait cycles, plus one fetch wait
        op = 6'b101011; mem_ready = 1'b0;
        cyc("sw_fetch_wait", 4'd1, E_FETCH_W);
        mem_ready = 1'b1;
        cyc("sw_fetch", 4'd1, E_FETCH);
        cyc("sw_decode", 4'd2, E_DEC);
        cyc("sw_memadr", 4'd3, E_MEMADR);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc("sw_memwr_wait", 4'd6, E_MEMWR_W);
        mem_ready = 1'b1;
        cyc("sw_memwr", 4'd6, E_MEMWR);

        // R-type then BEQ back to back
        op = 6'b000000;
        cyc("r_fetch", 4'd1, E_FETCH);
        cyc("r_decode", 4'd2, E_DEC);
        cyc("r_exec", 4'd7, E_EXEC);
        cyc("r_rwb", 4'd8, E_RWB);
        op = 6'b000100;
        cyc("beq_fetch", 4'd1, E_FETCH);
        cyc("beq_decode", 4'd2, E_DEC);
        cyc("beq_branch", 4'd9, E_BRANCH);

        // ADDI and J
        op = 6'b001000;
        cyc("addi_fetch", 4'd1, E_FETCH);
        cyc("addi_decode", 4'd2, E_DEC);
        cyc("addi_ex", 4'd11, E_ADDIEX);
        cyc("addi_wb", 4'd12, E_ADDIWB);
        op = 6'b000010;
        cyc("j_fetch", 4'd1, E_FETCH);
        cyc("j_decode", 4'd2, E_DEC);
        cyc("j_jump", 4'd10, E_JUMP);

        // Unknown opcode
        op = 6'b111111;
        cyc("ill_fetch", 4'd1, E_FETCH);
`ifdef MIPS_CTRL_ILLEGAL_OP_EN
        cyc("ill_decode", 4'd2, E_DEC);
        cyc("ill_exc", 4'd13, E_EXC);
`else
        cyc("ill_decode", 4'd2, E_DEC_NOP);
`endif

        // Asynchronous reset while a store is waiting in MEMWR
        op = 6'b101011;
        cyc("rst_fetch", 4'd1, E_FETCH);
        cyc("rst_decode", 4'd2, E_DEC);
        cyc("rst_memadr", 4'd3, E_MEMADR);
        mem_ready = 1'b0;
        @(negedge clk);
        check("rst_pre_mw", {31'd0, mem_write}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_async_mw", {31'd0, mem_write}, 32'd0);
        check("rst_async_state", {28'd0, state}, 32'd0);
        check("rst_async_ctl", {15'd0, ctl}, {15'd0, E_IDLE});
        mem_ready = 1'b1;
        @(posedge clk); #1;
        check("rst_held_state", {28'd0, state}, 32'd0);
        rst_n = 1'b1;
        cyc("rst_idle", 4'd0, E_IDLE);
        cyc("rst_refetch", 4'd1, E_FETCH);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Multi-cycle main control FSM for the MIPS datapath. It sequences one shared memory, ALU and register file through fetch/decode/execute/memory/writeback steps.
- Decodes the 6-bit opcode and drives every datapath select and enable once per state.
- Stalls in the memory-access states until the memory handshake completes.
- Sits between the instruction register's opcode field and the datapath muxes and enables.

Parameters:
OP_RTYPE, 6'b000000, R-type opcode
OP_LW, 6'b100011, load word opcode
OP_SW, 6'b101011, store word opcode
OP_BEQ, 6'b000100, branch-equal opcode
OP_J, 6'b000010, jump opcode
OP_ADDI, 6'b001000, add-immediate opcode

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
op  in  6  opcode from instruction register (bits 31:26)
mem_ready  in  1  memory completes current read/write this cycle
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if ALU zero (gated in datapath)
i_or_d  out  1  0=PC addresses memory, 1=ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  instruction register load
mem_to_reg  out  1  1=MDR to register write data
reg_dst  out  1  1=rd, 0=rt
reg_write  out  1  register file write
alu_src_a  out  1  0=PC, 1=A
alu_src_b  out  2  00=B, 01=4, 10=signext imm, 11=signext imm<<2
alu_op  out  2  00=add, 01=sub, 10=funct-decoded
pc_source  out  2  00=ALU, 01=ALUOut, 10=jump target, 11=exception vector
instr_done  out  1  one-cycle pulse in final state of each instruction
state  out  4  current state, for debug

Behaviour:
- Single 4-bit state register. The asynchronous active-low reset forces state=IDLE(0).
- IDLE drives all outputs 0. IDLE always goes to FETCH on the next clk.
- Outputs are combinational from state. The only exception is FETCH, where pc_write and ir_write are also gated by mem_ready.
- State encodings: IDLE 0, FETCH 1, DECODE 2, MEMADR 3, MEMRD 4, MEMWB 5, MEMWR 6, EXEC 7, RWB 8, BRANCH 9, JUMP 10, ADDIEX 11, ADDIWB 12, EXC 13. Values 14–15 are illegal and go to IDLE next cycle.
- Any output not listed for a state is 0.
- FETCH:
  - Outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; ir_write=pc_write=mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute).
  - Next state by op: LW/SW→MEMADR, RTYPE→EXEC, BEQ→BRANCH, J→JUMP, ADDI→ADDIEX, other→see Optional Feature.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to MEMRD if op=LW, else MEMWR.
- MEMRD: mem_read=1, i_or_d=1. Holds until mem_ready=1, then goes to MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1. Goes to FETCH.
- MEMWR: mem_write=1, i_or_d=1. Holds until mem_ready=1, then instr_done=1 that cycle and goes to FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Goes to RWB.
- RWB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1. Goes to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, instr_done=1. Goes to FETCH.
- JUMP: pc_write=1, pc_source=10, instr_done=1. Goes to FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1. Goes to FETCH.
- Cycles per instruction with mem_ready always 1: LW 5, SW 4, R-type 4, ADDI 4, BEQ 3, J 3. Each memory wait cycle adds 1.
- op is sampled only in DECODE and MEMADR. Changes to op in other states have no effect.
- Reset asserted mid-instruction: state returns to IDLE immediately and all outputs drop to 0 asynchronously. No partial write completes after reset.

Optional Feature:
MIPS_CTRL_ILLEGAL_OP_EN
- Defined: an unrecognised op in DECODE goes to EXC.
  - EXC drives pc_write=1, pc_source=11, instr_done=1, then goes to FETCH.
  - EXC does not assert reg_write or mem_write.
- Not defined: an unrecognised op in DECODE goes directly to FETCH (NOP). instr_done pulses in DECODE that cycle; state 13 is unreachable and treated as illegal.

Test Plan:
- rst_n=0 then release, mem_ready=1 → IDLE for 1 cycle (all outputs 0), then FETCH with mem_read=1, pc_write=1, ir_write=1, alu_src_b=01.
- op=6'b100011, mem_ready=1 → FETCH, DECODE, MEMADR, MEMRD, MEMWB (5 cycles); MEMWB has reg_write=1, mem_to_reg=1, instr_done=1.
- op=6'b101011, mem_ready low for 3 cycles in MEMWR → mem_write=1 held 4 cycles; instr_done pulses once with mem_ready; return to FETCH.
- op=6'b000000 then op=6'b000100 back to back → RWB has reg_dst=1, reg_write=1; BRANCH has pc_write_cond=1, alu_op=01, pc_source=01; instr_done pulses at cycles 4 and 7.
- rst_n driven low while in MEMWR with mem_write=1 → mem_write=0 within the same cycle (asynchronous); state=IDLE; after release, sequence restarts at FETCH.
- op=6'b111111 → with MIPS_CTRL_ILLEGAL_OP_EN: DECODE, EXC (pc_write=1, pc_source=11), then FETCH; without it: DECODE (instr_done=1), then FETCH.
